fpu_result_checker: RTL and testbench
=====================================

Name: fpu_result_checker

Overview:
- Downstream of the golden and faulty FPU circuit instances in the fault-emulation harness.
- Consumes both 41-bit result vectors after each issued test vector, waits for each side's READY bit, and compares the captured results under a mask.
- Maintains saturating test, mismatch and timeout counters, and presents one per-test report to the AXI readout logic over a valid/ready handshake.

Parameters:
- RES_W, 41: result vector width (golden and faulty).
- READY_BIT, 32: index of the READY flag inside a result vector.
- TIMEOUT, 64: maximum WAIT cycles before a test is declared timed out (≥2).
- CNT_W, 32: width of the statistics counters.
- CMP_MASK, {41{1'b1}}: bits included in the comparison.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse; a test vector was issued to both circuits (testVector[69]).
- golden_res_i  in  RES_W  golden circuit resultVector.
- faulty_res_i  in  RES_W  faulty circuit resultVector.
- clr_i  in  1  synchronous clear of counters and sticky flags.
- busy_o  out  1  high whenever state != IDLE.
- rpt_valid_o  out  1  report available.
- rpt_ready_i  in  1  readout accepts the report.
- rpt_diff_o  out  RES_W  (golden ^ faulty) & CMP_MASK for the reported test.
- rpt_mismatch_o  out  1  diff nonzero or timeout.
- rpt_timeout_o  out  1  the test timed out.
- test_cnt_o  out  CNT_W  completed tests.
- mism_cnt_o  out  CNT_W  tests with rpt_mismatch.
- tout_cnt_o  out  CNT_W  timed-out tests.
- overrun_o  out  1  sticky; start_i arrived while busy.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE, all outputs and counters 0, capture flags cleared, cycle counter 0.
- FSM states: IDLE, WAIT, CMP, REPORT.
- IDLE: start_i=1 → WAIT; clear g_got, f_got and the cycle counter.
- WAIT, each edge:
  - If golden_res_i[READY_BIT]=1 and !g_got: capture golden_res_i, set g_got.
  - If faulty_res_i[READY_BIT]=1 and !f_got: capture faulty_res_i, set f_got.
  - Only the first READY per side is captured; later READYs are ignored.
  - If both are captured (including captures on this edge) → CMP with tout=0.
  - Otherwise, if cycle counter == TIMEOUT-1 → CMP with tout=1; uncaptured sides compare as 0.
  - Otherwise the cycle counter increments.
  - A capture on the timeout edge that completes both sides takes priority over timeout.
- CMP, one cycle:
  - Register rpt_diff = (g ^ f) & CMP_MASK, rpt_timeout = tout, rpt_mismatch = |rpt_diff | tout.
  - test_cnt +1; mism_cnt +1 if mismatch; tout_cnt +1 if tout.
  - → REPORT.
- REPORT:
  - rpt_valid_o=1, payload held stable.
  - When rpt_valid_o & rpt_ready_i on an edge → IDLE, rpt_valid_o=0 next cycle.
  - rpt_ready_i is ignored when rpt_valid_o=0.
- Latency: if both READYs are sampled on edge k after the start edge, rpt_valid_o rises after edge k+2. Minimum start-to-valid is 3 edges.
- start_i while busy_o=1: ignored, overrun_o set (sticky). start_i in IDLE is accepted normally.
- Counters saturate at 2^CNT_W-1; no wrap.
- clr_i=1: counters and overrun_o → 0 on that edge; clear wins over a simultaneous increment or overrun set. FSM and report are unaffected.
- Reset mid-test: immediate return to IDLE, the pending report is discarded, and counters are zeroed.

Test Plan:
- Reset, then start; golden and faulty both return 0x0_3F800000 with READY at cycle 5 → rpt_valid after edge 7, diff=0, mismatch=0, test_cnt=1, mism_cnt=0.
- Golden READY at cycle 4 with 0x3F800000; faulty READY at cycle 9 with 0x3F800001 → report after faulty capture +2 edges, diff=0x0_00000001, mismatch=1, mism_cnt=1.
- Faulty never asserts READY, TIMEOUT=64 → timeout on WAIT edge 63, rpt_timeout=1, mismatch=1, diff = golden value masked (faulty=0), tout_cnt=1.
- Hold rpt_ready_i=0 for 10 cycles and pulse start_i during REPORT → payload stable, overrun_o=1, no new test started; rpt_ready_i=1 → IDLE.
- CNT_W=4: run 17 matching tests → test_cnt=15 (saturated); clr_i coincident with the 18th CMP → test_cnt=0.
- Assert rst during WAIT at cycle 3 → all outputs 0 immediately, busy_o=0; the next start runs a full test normally.

Source files
------------

// File: rtl/fpu_result_checker_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_result_checker_if
//   Per-test report handshake between the result checker and AXI readout.
//   Revision: 1.0
// ----------------------------------------------------------------------------
interface fpu_result_checker_if #(
  parameter int RES_W = 41
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic [RES_W-1:0] rpt_diff;
  logic             rpt_mismatch;
  logic             rpt_timeout;

  modport master (
    output rpt_valid,
    input  rpt_ready,
    output rpt_diff,
    output rpt_mismatch,
    output rpt_timeout
  );

  modport slave (
    input  rpt_valid,
    output rpt_ready,
    input  rpt_diff,
    input  rpt_mismatch,
    input  rpt_timeout
  );
endinterface
`default_nettype wire

// File: rtl/fpu_result_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_result_checker
//   Captures golden/faulty FPU results, compares them under a mask, keeps
//   saturating statistics and hands one report per test to the readout.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module fpu_result_checker #(
  parameter int               RES_W     = 41,
  parameter int               READY_BIT = 32,
  parameter int               TIMEOUT   = 64,
  parameter int               CNT_W     = 32,
  parameter logic [RES_W-1:0] CMP_MASK  = {RES_W{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [RES_W-1:0]    golden_res_i,
  input  logic [RES_W-1:0]    faulty_res_i,
  input  logic                clr_i,
  output logic                busy_o,
  fpu_result_checker_if.master rpt,
  output logic [CNT_W-1:0]    test_cnt_o,
  output logic [CNT_W-1:0]    mism_cnt_o,
  output logic [CNT_W-1:0]    tout_cnt_o,
  output logic                overrun_o
);

  localparam int               CYC_W    = $clog2(TIMEOUT);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    CMP    = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t           state;
  logic [RES_W-1:0] g_cap;
  logic [RES_W-1:0] f_cap;
  logic             g_got;
  logic             f_got;
  logic             tout;
  logic [CYC_W-1:0] cyc;

  logic             rpt_valid_q;
  logic [RES_W-1:0] rpt_diff_q;
  logic             rpt_mismatch_q;
  logic             rpt_timeout_q;

  logic             g_take;
  logic             f_take;
  logic             both_done;
  logic [RES_W-1:0] cmp_diff;
  logic             cmp_mism;

  // Only the first READY seen on each side is latched.
  assign g_take    = (state == WAIT) & golden_res_i[READY_BIT] & ~g_got;
  assign f_take    = (state == WAIT) & faulty_res_i[READY_BIT] & ~f_got;
  assign both_done = (g_got | g_take) & (f_got | f_take);

  // Uncaptured sides are still zero from the IDLE clear.
  assign cmp_diff  = (g_cap ^ f_cap) & CMP_MASK;
  assign cmp_mism  = (|cmp_diff) | tout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      g_cap          <= '0;
      f_cap          <= '0;
      g_got          <= 1'b0;
      f_got          <= 1'b0;
      tout           <= 1'b0;
      cyc            <= '0;
      rpt_valid_q    <= 1'b0;
      rpt_diff_q     <= '0;
      rpt_mismatch_q <= 1'b0;
      rpt_timeout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= WAIT;
            g_got <= 1'b0;
            f_got <= 1'b0;
            g_cap <= '0;
            f_cap <= '0;
            tout  <= 1'b0;
            cyc   <= '0;
          end
        end
        WAIT: begin
          if (g_take) begin
            g_cap <= golden_res_i;
            g_got <= 1'b1;
          end
          if (f_take) begin
            f_cap <= faulty_res_i;
            f_got <= 1'b1;
          end
          // Completing both sides on the last cycle beats the timeout.
          if (both_done) begin
            tout  <= 1'b0;
            state <= CMP;
          end else if (cyc == CYC_LAST) begin
            tout  <= 1'b1;
            state <= CMP;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        CMP: begin
          rpt_diff_q     <= cmp_diff;
          rpt_timeout_q  <= tout;
          rpt_mismatch_q <= cmp_mism;
          rpt_valid_q    <= 1'b1;
          state          <= REPORT;
        end
        REPORT: begin
          if (rpt.rpt_ready) begin
            rpt_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Clear has priority over any increment or overrun set on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_cnt_o <= '0;
      mism_cnt_o <= '0;
      tout_cnt_o <= '0;
      overrun_o  <= 1'b0;
    end else if (clr_i) begin
      test_cnt_o <= '0;
      mism_cnt_o <= '0;
      tout_cnt_o <= '0;
      overrun_o  <= 1'b0;
    end else begin
      if (start_i && (state != IDLE)) begin
        overrun_o <= 1'b1;
      end
      if (state == CMP) begin
        test_cnt_o <= sat_inc(test_cnt_o);
        if (cmp_mism) begin
          mism_cnt_o <= sat_inc(mism_cnt_o);
        end
        if (tout) begin
          tout_cnt_o <= sat_inc(tout_cnt_o);
        end
      end
    end
  end

  assign busy_o           = (state != IDLE);
  assign rpt.rpt_valid    = rpt_valid_q;
  assign rpt.rpt_diff     = rpt_diff_q;
  assign rpt.rpt_mismatch = rpt_mismatch_q;
  assign rpt.rpt_timeout  = rpt_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fpu_result_checker
//   Directed table plus randomized tests against a spec-level result model.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fpu_result_checker;

  localparam int              RES_W   = 41;
  localparam int              TIMEOUT = 64;
  localparam logic [RES_W-1:0] RDY    = 41'h1_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             start, clr, busy, overrun;
  logic [RES_W-1:0] gres, fres;
  logic [31:0]      tcnt, mcnt, ocnt;
  fpu_result_checker_if #(.RES_W(RES_W)) rif ();

  fpu_result_checker #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .golden_res_i(gres),
    .faulty_res_i(fres), .clr_i(clr), .busy_o(busy), .rpt(rif),
    .test_cnt_o(tcnt), .mism_cnt_o(mcnt), .tout_cnt_o(ocnt), .overrun_o(overrun)
  );

  logic             start2, clr2, busy2, overrun2;
  logic [RES_W-1:0] gres2, fres2;
  logic [3:0]       tcnt2, mcnt2, ocnt2;
  fpu_result_checker_if #(.RES_W(RES_W)) rif2 ();

  fpu_result_checker #(.TIMEOUT(4), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .golden_res_i(gres2),
    .faulty_res_i(fres2), .clr_i(clr2), .busy_o(busy2), .rpt(rif2),
    .test_cnt_o(tcnt2), .mism_cnt_o(mcnt2), .tout_cnt_o(ocnt2), .overrun_o(overrun2)
  );

  int checks = 0;
  int failures = 0;
  int unsigned m_tests = 0, m_mism = 0, m_tout = 0;
  logic m_over = 1'b0;

  typedef struct {
    int               gr;
    int               fr;
    logic [RES_W-1:0] gv;
    logic [RES_W-1:0] fv;
    logic [RES_W-1:0] diff;
    logic             mism;
    logic             tout;
    int               hold;
    bit               pulse;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RES_W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[RES_W-1:0];
  endfunction

  // Word presented by one side on WAIT cycle c when its READY first appears on cycle r.
  function automatic logic [RES_W-1:0] side_word(input int r, input int c, input logic [RES_W-1:0] v);
    if (r < 0 || c < r) return rnd() & ~RDY;
    if (c == r)         return v;
    return rnd() | RDY;
  endfunction

  // Reference: a side counts only if its READY lands inside the TIMEOUT window.
  task automatic model(input int gr, input int fr, input logic [RES_W-1:0] gv,
                       input logic [RES_W-1:0] fv, output logic [RES_W-1:0] diff,
                       output logic mism, output logic tout);
    bit g_in, f_in;
    g_in = (gr >= 0) && (gr < TIMEOUT);
    f_in = (fr >= 0) && (fr < TIMEOUT);
    tout = !(g_in && f_in);
    diff = (g_in ? gv : '0) ^ (f_in ? fv : '0);
    mism = (diff != '0) || tout;
  endtask

  task automatic run_one(input int gr, input int fr, input logic [RES_W-1:0] gv,
                         input logic [RES_W-1:0] fv, input logic [RES_W-1:0] ediff,
                         input logic emism, input logic etout, input int hold, input bit pulse);
    int done_idx;
    done_idx = (gr >= 0 && fr >= 0 && gr < TIMEOUT && fr < TIMEOUT) ?
               ((gr > fr) ? gr : fr) : TIMEOUT - 1;
    start = 1'b1;
    gres  = rnd() & ~RDY;
    fres  = rnd() & ~RDY;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int c = 0; c <= done_idx; c++) begin
      gres = side_word(gr, c, gv);
      fres = side_word(fr, c, fv);
      tick();
    end
    chk("valid_low_in_cmp", rif.rpt_valid, 0);
    gres = rnd() | RDY;
    fres = rnd() | RDY;
    tick();
    m_tests++;
    if (emism) m_mism++;
    if (etout) m_tout++;
    chk("rpt_valid", rif.rpt_valid, 1);
    chk("rpt_diff", rif.rpt_diff, ediff);
    chk("rpt_mismatch", rif.rpt_mismatch, emism);
    chk("rpt_timeout", rif.rpt_timeout, etout);
    chk("test_cnt", tcnt, m_tests);
    chk("mism_cnt", mcnt, m_mism);
    chk("tout_cnt", ocnt, m_tout);
    for (int h = 0; h < hold; h++) begin
      start = pulse && (h == 0);
      if (start) m_over = 1'b1;
      tick();
      start = 1'b0;
      chk("hold_valid", rif.rpt_valid, 1);
      chk("hold_diff", rif.rpt_diff, ediff);
    end
    chk("overrun", overrun, m_over);
    rif.rpt_ready = 1'b1;
    tick();
    rif.rpt_ready = 1'b0;
    chk("valid_drop", rif.rpt_valid, 0);
    chk("busy_idle", busy, 0);
    tick();
    chk("no_new_test", busy, 0);
  endtask

  task automatic run2(input bit clr_at_cmp);
    start2 = 1'b1;
    gres2  = '0;
    fres2  = '0;
    tick();
    start2 = 1'b0;
    gres2  = RDY | 41'h3F80_0000;
    fres2  = RDY | 41'h3F80_0000;
    tick();
    clr2  = clr_at_cmp;
    gres2 = '0;
    fres2 = '0;
    tick();
    clr2 = 1'b0;
    chk("d2_valid", rif2.rpt_valid, 1);
    chk("d2_mismatch", rif2.rpt_mismatch, 0);
    rif2.rpt_ready = 1'b1;
    tick();
    rif2.rpt_ready = 1'b0;
  endtask

  initial begin
    logic [RES_W-1:0] ed, gv, fv;
    logic             em, et;
    int               gr, fr;

    tbl[0] = '{5,  5,  41'h1_3F80_0000, 41'h1_3F80_0000, 41'h0,           1'b0, 1'b0, 0,  1'b0};
    tbl[1] = '{4,  9,  41'h1_3F80_0000, 41'h1_3F80_0001, 41'h0_0000_0001, 1'b1, 1'b0, 2,  1'b0};
    tbl[2] = '{3,  -1, 41'h1_3F80_0000, 41'h0,           41'h1_3F80_0000, 1'b1, 1'b1, 0,  1'b0};
    tbl[3] = '{0,  0,  41'h1_4049_0FDB, 41'h1_4049_0FDB, 41'h0,           1'b0, 1'b0, 10, 1'b1};
    tbl[4] = '{63, 10, 41'h1_0000_0002, 41'h1_0000_0000, 41'h0_0000_0002, 1'b1, 1'b0, 1,  1'b0};
    tbl[5] = '{-1, -1, 41'h0,           41'h0,           41'h0,           1'b1, 1'b1, 0,  1'b0};
    tbl[6] = '{64, 2,  41'h1_0000_0005, 41'h1_C000_0000, 41'h1_C000_0000, 1'b1, 1'b1, 0,  1'b0};

    rst = 1'b1; start = 1'b0; clr = 1'b0; gres = '0; fres = '0; rif.rpt_ready = 1'b0;
    start2 = 1'b0; clr2 = 1'b0; gres2 = '0; fres2 = '0; rif2.rpt_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("reset_busy", busy, 0);
    chk("reset_valid", rif.rpt_valid, 0);
    chk("reset_diff", rif.rpt_diff, 0);
    chk("reset_cnts", {tcnt, mcnt}, 0);
    chk("reset_overrun", overrun, 0);

    for (int i = 0; i < 7; i++)
      run_one(tbl[i].gr, tbl[i].fr, tbl[i].gv, tbl[i].fv, tbl[i].diff,
              tbl[i].mism, tbl[i].tout, tbl[i].hold, tbl[i].pulse);

    for (int i = 0; i < 20; i++) begin
      gr = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 70));
      fr = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 70));
      gv = rnd() | RDY;
      fv = ($urandom_range(0, 1) == 0) ? gv : (rnd() | RDY);
      model(gr, fr, gv, fv, ed, em, et);
      run_one(gr, fr, gv, fv, ed, em, et, int'($urandom_range(0, 3)), 1'b0);
    end

    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_tests = 0; m_mism = 0; m_tout = 0; m_over = 1'b0;
    chk("clr_cnts", {tcnt, mcnt, ocnt}, 0);
    chk("clr_overrun", overrun, 0);

    // Reset in the middle of a wait
    start = 1'b1;
    tick();
    start = 1'b0;
    gres = '0;
    fres = '0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", rif.rpt_valid, 0);
    chk("midrst_cnt", tcnt, 0);
    #2;
    rst = 1'b0;
    tick();
    run_one(2, 6, 41'h1_0000_0010, 41'h1_0000_0030, 41'h0_0000_0020, 1'b1, 1'b0, 0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      run2(1'b0);
      chk("d2_test_cnt", tcnt2, (i + 1 > 15) ? 15 : i + 1);
    end
    chk("d2_mism_cnt", mcnt2, 0);
    run2(1'b1);
    chk("d2_clr_at_cmp", tcnt2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
